// File: rtl/gmii_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gmii_pkg                                                                   |
// | Shared state encoding, framing constants and CRC-32 byte update.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_ABORT    = 3'd6,
        ST_IFG      = 3'd7
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam int unsigned PREAMBLE_LEN  = 7;

    // Reflected CRC-32: byte enters LSB first.
    function automatic logic [31:0] crc32_update(input logic [31:0] crc,
                                                 input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gmii_tx_framer_crc32_byte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crc32_byte                                                                 |
// | Byte-per-enable CRC-32 engine with synchronous re-initialise.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module crc32_byte
    import gmii_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= CRC_INIT;
        end else if (i_init) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= crc32_update(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/gmii_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gmii_tx_framer                                                             |
// | Client byte stream to GMII: preamble/SFD, padding, FCS, abort and IFG.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gmii_tx_framer
    import gmii_pkg::*;
#(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic        CLK125,
    input  logic        SGMII_RESET,
    input  logic        SGMII_CLK_EN,
    input  logic [7:0]  TX_DATA,
    input  logic        TX_VALID,
    input  logic        TX_LAST,
    input  logic        TX_ERR,
    output logic        TX_READY,
    output logic [7:0]  GMII_TXD,
    output logic        GMII_TX_EN,
    output logic        GMII_TX_ER,
    output logic        TX_BUSY,
    output logic [15:0] FRAME_CNT
);

    localparam logic [10:0] c_cnt_max     = 11'd2047;
    localparam logic [10:0] c_min_payload = 11'(MIN_PAYLOAD);
    localparam logic [10:0] c_ifg_last    = 11'(IFG_BYTES - 1);
    localparam logic [10:0] c_pre_last    = 11'(PREAMBLE_LEN - 1);

    tx_state_t   r_state;
    logic [10:0] r_cnt;
    logic        r_err;
    logic [7:0]  r_txd;
    logic        r_tx_en;
    logic        r_tx_er;
    logic [15:0] r_frame_cnt;

    logic [10:0] w_cnt_inc;
    logic        w_crc_init;
    logic        w_crc_en;
    logic [7:0]  w_crc_data;
    logic [31:0] w_crc;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;

    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 11'd1;
    assign w_crc_init = SGMII_CLK_EN && (r_state == ST_SFD);
    assign w_crc_en   = SGMII_CLK_EN &&
                        (((r_state == ST_DATA) && TX_VALID) || (r_state == ST_PAD));
    assign w_crc_data = (r_state == ST_PAD) ? 8'h00 : TX_DATA;

    // An errored frame sends the raw remainder, i.e. the complement of the good FCS.
    assign w_fcs      = r_err ? w_crc : ~w_crc;
    assign w_fcs_byte = w_fcs[{r_cnt[1:0], 3'b000} +: 8];

    crc32_byte u_crc (
        .clk    (CLK125),
        .rst    (SGMII_RESET),
        .i_init (w_crc_init),
        .i_en   (w_crc_en),
        .i_data (w_crc_data),
        .o_crc  (w_crc)
    );

    // Each enabled edge emits the byte for the current state; the first preamble
    // byte leaves with the IDLE edge so back-to-back gaps are exactly IFG_BYTES.
    always_ff @(posedge CLK125 or posedge SGMII_RESET) begin
        if (SGMII_RESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_txd       <= 8'h00;
            r_tx_en     <= 1'b0;
            r_tx_er     <= 1'b0;
            r_frame_cnt <= '0;
        end else if (SGMII_CLK_EN) begin
            r_txd   <= 8'h00;
            r_tx_en <= 1'b0;
            r_tx_er <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (TX_VALID) begin
                        r_txd   <= PREAMBLE_BYTE;
                        r_tx_en <= 1'b1;
                        r_cnt   <= 11'd1;
                        r_state <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    r_txd   <= PREAMBLE_BYTE;
                    r_tx_en <= 1'b1;
                    if (r_cnt == c_pre_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_SFD;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                ST_SFD: begin
                    r_txd   <= SFD_BYTE;
                    r_tx_en <= 1'b1;
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    r_tx_en <= 1'b1;
                    if (TX_VALID) begin
                        r_txd   <= TX_DATA;
                        r_tx_er <= TX_ERR;
                        r_err   <= r_err | TX_ERR;
                        r_cnt   <= w_cnt_inc;
                        if (TX_LAST) begin
                            if (w_cnt_inc < c_min_payload) begin
                                r_state <= ST_PAD;
                            end else begin
                                r_cnt   <= '0;
                                r_state <= ST_FCS;
                            end
                        end
                    end else begin
                        r_tx_er <= 1'b1;
                        r_state <= ST_ABORT;
                    end
                end
                ST_PAD: begin
                    r_tx_en <= 1'b1;
                    r_cnt   <= w_cnt_inc;
                    if (w_cnt_inc >= c_min_payload) begin
                        r_cnt   <= '0;
                        r_state <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    r_txd   <= w_fcs_byte;
                    r_tx_en <= 1'b1;
                    if (r_cnt[1:0] == 2'd3) begin
                        r_cnt       <= '0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= ST_IFG;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                ST_ABORT: begin
                    // The abort byte went out on entry; this edge is the first gap byte.
                    r_cnt   <= 11'd1;
                    r_state <= (IFG_BYTES > 1) ? ST_IFG : ST_IDLE;
                end
                ST_IFG: begin
                    if (r_cnt >= c_ifg_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX_READY   = (r_state == ST_DATA) && SGMII_CLK_EN && !SGMII_RESET;
    assign TX_BUSY    = (r_state != ST_IDLE);
    assign GMII_TXD   = r_txd;
    assign GMII_TX_EN = r_tx_en;
    assign GMII_TX_ER = r_tx_er;
    assign FRAME_CNT  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gmii_tx_framer                                                          |
// | Randomised frames compared against a byte-stream model of the framer.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_gmii_tx_framer;

    localparam int IFG_BYTES   = 12;
    localparam int MIN_PAYLOAD = 60;

    typedef logic [7:0] bq_t[$];
    typedef logic [9:0] wq_t[$];

    logic        CLK125       = 1'b0;
    logic        SGMII_RESET  = 1'b1;
    logic        SGMII_CLK_EN = 1'b1;
    logic [7:0]  TX_DATA      = 8'h00;
    logic        TX_VALID     = 1'b0;
    logic        TX_LAST      = 1'b0;
    logic        TX_ERR       = 1'b0;
    logic        TX_READY;
    logic [7:0]  GMII_TXD;
    logic        GMII_TX_EN;
    logic        GMII_TX_ER;
    logic        TX_BUSY;
    logic [15:0] FRAME_CNT;

    gmii_tx_framer #(.IFG_BYTES(IFG_BYTES), .MIN_PAYLOAD(MIN_PAYLOAD)) dut (
        .CLK125       (CLK125),
        .SGMII_RESET  (SGMII_RESET),
        .SGMII_CLK_EN (SGMII_CLK_EN),
        .TX_DATA      (TX_DATA),
        .TX_VALID     (TX_VALID),
        .TX_LAST      (TX_LAST),
        .TX_ERR       (TX_ERR),
        .TX_READY     (TX_READY),
        .GMII_TXD     (GMII_TXD),
        .GMII_TX_EN   (GMII_TX_EN),
        .GMII_TX_ER   (GMII_TX_ER),
        .TX_BUSY      (TX_BUSY),
        .FRAME_CNT    (FRAME_CNT)
    );

    always #4 CLK125 = ~CLK125;

    int n_checks = 0;
    int n_fail   = 0;
    int en_period = 1;
    int en_div    = 0;
    int hold_err  = 0;
    int ready_err = 0;
    logic [15:0] exp_cnt = 16'd0;
    wq_t cap;
    logic       mon_en;
    logic [9:0] mon_cur;
    logic [9:0] mon_last = 10'h000;

    always @(negedge CLK125) begin
        en_div = (en_div + 1 >= en_period) ? 0 : en_div + 1;
        SGMII_CLK_EN = (en_div == 0);
    end

    // One captured word {er,en,txd} per byte time; outputs must not move otherwise.
    always @(posedge CLK125) begin
        mon_en = SGMII_CLK_EN;
        #1;
        mon_cur = {GMII_TX_ER, GMII_TX_EN, GMII_TXD};
        if (!SGMII_RESET) begin
            if (mon_en) cap.push_back(mon_cur);
            else if (mon_cur !== mon_last) hold_err++;
        end
        mon_last = mon_cur;
    end

    always @(negedge CLK125) begin
        #1;
        if (TX_READY && !SGMII_CLK_EN) ready_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // zlib CRC-32, processed one bit at a time over the whole frame body.
    function automatic logic [31:0] ref_crc(input bq_t d);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    // Expected on-wire words; abort_after >= 0 means the client stalls after that many bytes.
    function automatic wq_t exp_frame(input bq_t d, input int err_at, input int abort_after);
        wq_t         w;
        bq_t         body;
        logic [31:0] fcs;
        for (int i = 0; i < 7; i++) w.push_back({2'b01, 8'h55});
        w.push_back({2'b01, 8'hD5});
        if (abort_after >= 0) begin
            for (int i = 0; i < abort_after; i++) w.push_back({(i == err_at), 1'b1, d[i]});
            w.push_back({2'b11, 8'h00});
            return w;
        end
        foreach (d[i]) begin
            w.push_back({(i == err_at), 1'b1, d[i]});
            body.push_back(d[i]);
        end
        while (body.size() < MIN_PAYLOAD) begin
            w.push_back({2'b01, 8'h00});
            body.push_back(8'h00);
        end
        fcs = ref_crc(body);
        if (err_at >= 0 && err_at < d.size()) fcs = ~fcs;
        for (int k = 0; k < 4; k++) w.push_back({2'b01, fcs[8*k +: 8]});
        return w;
    endfunction

    task automatic drive(input bq_t d, input int err_at, input int stop_after, output bit ok);
        int n;
        ok = 1'b1;
        for (int i = 0; i < d.size(); i++) begin
            if (i == stop_after) return;
            TX_VALID = 1'b1;
            TX_DATA  = d[i];
            TX_LAST  = (i == d.size() - 1);
            TX_ERR   = (i == err_at);
            n = 0;
            do begin
                @(negedge CLK125);
                #2;
                n++;
            end while (!TX_READY && n < 5000);
            if (!TX_READY) begin
                ok = 1'b0;
                return;
            end
            @(posedge CLK125);
            #1;
        end
        TX_LAST = 1'b0;
        TX_ERR  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (TX_BUSY && n < 20000) begin
            @(posedge CLK125);
            n++;
        end
        check({tag, "_busy_timeout"}, 32'(TX_BUSY), 32'd0);
        repeat (3) @(posedge CLK125);
        #2;
    endtask

    task automatic check_stream(input string tag, input wq_t exp);
        int         s;
        int         nz;
        logic [9:0] got;
        s  = -1;
        nz = 0;
        foreach (cap[i]) if (s < 0 && cap[i][8]) s = i;
        check({tag, "_start"}, 32'(s >= 0), 32'd1);
        if (s < 0) return;
        for (int i = 0; i < exp.size(); i++) begin
            got = (s + i < cap.size()) ? cap[s + i] : 10'bx;
            check($sformatf("%s[%0d]", tag, i), 32'(got), 32'(exp[i]));
        end
        check({tag, "_gap_len"}, 32'(cap.size() - s - exp.size() >= IFG_BYTES), 32'd1);
        for (int i = s + exp.size(); i < cap.size(); i++) if (cap[i] != 10'h000) nz++;
        check({tag, "_gap_idle"}, 32'(nz), 32'd0);
    endtask

    task automatic run_frame(input string tag, input bq_t d, input int err_at);
        bit ok;
        cap.delete();
        drive(d, err_at, -1, ok);
        TX_VALID = 1'b0;
        check({tag, "_ready"}, 32'(ok), 32'd1);
        wait_idle(tag);
        exp_cnt++;
        check_stream(tag, exp_frame(d, err_at, -1));
        check({tag, "_frame_cnt"}, 32'(FRAME_CNT), 32'(exp_cnt));
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t d;
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        return d;
    endfunction

    initial begin
        bq_t d, d2;
        wq_t e, e2;
        bit  ok;
        int  len, err_at;

        repeat (3) @(posedge CLK125);
        #1;
        check("rst_txd",   32'(GMII_TXD),   32'd0);
        check("rst_en",    32'(GMII_TX_EN), 32'd0);
        check("rst_er",    32'(GMII_TX_ER), 32'd0);
        check("rst_busy",  32'(TX_BUSY),    32'd0);
        check("rst_cnt",   32'(FRAME_CNT),  32'd0);
        check("rst_ready", 32'(TX_READY),   32'd0);
        @(negedge CLK125);
        SGMII_RESET = 1'b0;
        repeat (4) @(posedge CLK125);
        #2;
        check("idle_en",   32'(GMII_TX_EN), 32'd0);
        check("idle_busy", 32'(TX_BUSY),    32'd0);

        d = {};
        for (int i = 0; i < 64; i++) d.push_back(8'(i));
        run_frame("inc64", d, -1);

        d2 = {};
        d2.push_back(8'hAB);
        run_frame("one_byte", d2, -1);

        hold_err  = 0;
        ready_err = 0;
        en_period = 10;
        run_frame("div10", d, -1);
        check("div10_hold",  32'(hold_err),  32'd0);
        check("div10_ready", 32'(ready_err), 32'd0);
        en_period = 1;
        repeat (12) @(posedge CLK125);

        d = rand_bytes(40);
        cap.delete();
        drive(d, -1, 20, ok);
        TX_VALID = 1'b0;
        check("underrun_ready", 32'(ok), 32'd1);
        wait_idle("underrun");
        check_stream("underrun", exp_frame(d, -1, 20));
        check("underrun_frame_cnt", 32'(FRAME_CNT), 32'(exp_cnt));

        d  = rand_bytes(60);
        d2 = rand_bytes(60);
        cap.delete();
        drive(d, -1, -1, ok);
        check("b2b_ready1", 32'(ok), 32'd1);
        drive(d2, -1, -1, ok);
        TX_VALID = 1'b0;
        check("b2b_ready2", 32'(ok), 32'd1);
        wait_idle("b2b");
        e = exp_frame(d, -1, -1);
        for (int i = 0; i < IFG_BYTES; i++) e.push_back(10'h000);
        e2 = exp_frame(d2, -1, -1);
        foreach (e2[i]) e.push_back(e2[i]);
        exp_cnt += 16'd2;
        check_stream("b2b", e);
        check("b2b_frame_cnt", 32'(FRAME_CNT), 32'(exp_cnt));

        d = rand_bytes(64);
        cap.delete();
        drive(d, -1, 30, ok);
        check("rstmid_ready", 32'(ok), 32'd1);
        #2;
        SGMII_RESET = 1'b1;
        #1;
        check("rstmid_en",    32'(GMII_TX_EN), 32'd0);
        check("rstmid_txd",   32'(GMII_TXD),   32'd0);
        check("rstmid_er",    32'(GMII_TX_ER), 32'd0);
        check("rstmid_busy",  32'(TX_BUSY),    32'd0);
        check("rstmid_ready", 32'(TX_READY),   32'd0);
        check("rstmid_cnt",   32'(FRAME_CNT),  32'd0);
        TX_VALID = 1'b0;
        exp_cnt  = 16'd0;
        repeat (3) @(posedge CLK125);
        @(negedge CLK125);
        SGMII_RESET = 1'b0;
        repeat (IFG_BYTES + 3) @(posedge CLK125);
        #2;
        e = exp_frame(d, -1, 30);
        void'(e.pop_back());
        check_stream("truncated", e);
        run_frame("after_rst", rand_bytes(48), -1);

        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 2))
                0:       en_period = 1;
                1:       en_period = 3;
                default: en_period = 10;
            endcase
            len    = $urandom_range(1, 90);
            err_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            run_frame($sformatf("rnd%0d", k), rand_bytes(len), err_at);
        end
        check("final_hold",  32'(hold_err),  32'd0);
        check("final_ready", 32'(ready_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
